// File: rtl/mmio_bus_ctrl.sv
// CPU load/store sequencer: decodes a latched byte address to data memory or the LED/switch/7-seg
// registers, times the memory read latency and returns load data with a one-cycle completion pulse.
module mmio_bus_ctrl #(
  parameter int unsigned MEM_ADDR_W = 14,
  parameter int unsigned MEM_LAT    = 1,
  parameter logic [31:0] LED_ADDR   = 32'hFFFF_FC60,
  parameter logic [31:0] SW_ADDR    = 32'hFFFF_FC70,
  parameter logic [31:0] SEG_ADDR   = 32'hFFFF_FC80
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  req_done,
  output logic [31:0]           rsp_rdata,
  output logic                  req_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic [15:0]           sw_in,
  output logic [15:0]           led_out,
  output logic [31:0]           seg_out
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_e;
  typedef enum logic [2:0] {R_MEM, R_LED, R_SW, R_SEG, R_ERR} region_e;

  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

  function automatic region_e decode(input logic [31:0] a);
    if (a[1:0] != 2'b00)                       return R_ERR;
    if ((a >> (MEM_ADDR_W + 2)) == 32'd0)      return R_MEM;
    if (a == LED_ADDR)                         return R_LED;
    if (a == SW_ADDR)                          return R_SW;
    if (a == SEG_ADDR)                         return R_SEG;
    return R_ERR;
  endfunction

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [15:0] led_q, led_d;
  logic [31:0] seg_q, seg_d;
  logic [15:0] sw_meta_q, sw_sync_q;
  region_e     region;

  assign region = decode(addr_q);

  always_comb begin
    // NOTE: every next-state signal takes its held value first, so no path can infer a latch.
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    led_d   = led_q;
    seg_d   = seg_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          write_d = req_write;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        state_d = S_DONE;
        done_d  = 1'b1;
        unique case (region)
          R_MEM: begin
            if (!write_q) begin
              cnt_d   = LAT_M1;
              state_d = S_WAIT;
              done_d  = 1'b0;
            end
          end
          R_LED: begin
            if (write_q) led_d = wdata_q[15:0];
            else         rdata_d = {16'b0, led_q};
          end
          R_SW: begin
            if (!write_q) rdata_d = {16'b0, sw_sync_q};
          end
          R_SEG: begin
            if (write_q) seg_d = wdata_q;
            else         rdata_d = seg_q;
          end
          default: begin
            err_d = 1'b1;
            if (!write_q) rdata_d = 32'b0;
          end
        endcase
      end
      S_WAIT: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          rdata_d = mem_rdata;
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      led_q     <= '0;
      seg_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      done_q    <= done_d;
      err_q     <= err_d;
      led_q     <= led_d;
      seg_q     <= seg_d;
      sw_meta_q <= sw_in;
      sw_sync_q <= sw_meta_q;
    end
  end

  // Gating with !rst guarantees a reset landing mid-access never writes memory.
  assign mem_en    = (state_q == S_ACCESS) && (region == R_MEM) && !rst;
  assign mem_we    = mem_en && write_q;
  assign mem_addr  = addr_q[MEM_ADDR_W+1:2];
  assign mem_wdata = wdata_q;
  assign req_done  = done_q;
  assign req_err   = err_q;
  assign rsp_rdata = rdata_q;
  assign led_out   = led_q;
  assign seg_out   = seg_q;

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Directed bench for mmio_bus_ctrl: a table of sequential CPU accesses against a synchronous memory
// model, plus hand-written reset and abort sequences.
module tb_mmio_bus_ctrl;

  localparam logic [31:0] LED_A = 32'hFFFF_FC60;
  localparam logic [31:0] SW_A  = 32'hFFFF_FC70;
  localparam logic [31:0] SEG_A = 32'hFFFF_FC80;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_done;
  logic [31:0] rsp_rdata;
  logic        req_err;
  logic        mem_en;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [15:0] sw_in = '0;
  logic [15:0] led_out;
  logic [31:0] seg_out;

  int n_checks = 0;
  int n_fail   = 0;

  bit [31:0] mem_model [16384];

  mmio_bus_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_done(req_done), .rsp_rdata(rsp_rdata), .req_err(req_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .sw_in(sw_in), .led_out(led_out), .seg_out(seg_out)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_model[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_model[mem_addr];
    end
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [15:0] sw;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    logic [15:0] led;
    logic [31:0] seg;
    int          en;
    int          we;
    logic [13:0] maddr;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issues one request from a negedge and returns what was seen up to and including req_done.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output int en_n, output int we_n, output logic [13:0] maddr);
    lat = 0; en_n = 0; we_n = 0; rdata = '0; err = 1'b0; maddr = '0;
    req_write = wr; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (mem_en) begin en_n++; maddr = mem_addr; end
      if (mem_we) we_n++;
      if (lat == 1) begin
        req_addr = ~addr; req_wdata = ~wdata; req_write = ~wr;
      end
      if (req_done) break;
    end
    rdata = rsp_rdata;
    err   = req_err;
    req_valid = 1'b0;
  endtask

  function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [15:0] sw, input int lat, input logic [31:0] rdata,
                              input logic err, input logic [15:0] led, input logic [31:0] seg,
                              input int en, input int we, input logic [13:0] maddr);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.sw = sw; v.lat = lat; v.rdata = rdata;
    v.err = err; v.led = led; v.seg = seg; v.en = en; v.we = we; v.maddr = maddr;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, en_n, we_n;
    logic [31:0] rdata;
    logic        err;
    logic [13:0] maddr;

    //             wr    addr          wdata          sw        lat rdata          err  led       seg           en we maddr
    vecs[0]  = mk(1'b1, LED_A,        32'h0000_ABCD, 16'h0000, 2, 32'h0000_0000, 1'b0, 16'hABCD, 32'h0,        0, 0, 14'h0);
    vecs[1]  = mk(1'b1, 32'h10,       32'hDEAD_BEEF, 16'h0000, 2, 32'h0000_0000, 1'b0, 16'hABCD, 32'h0,        1, 1, 14'h4);
    vecs[2]  = mk(1'b0, 32'h10,       32'h0,         16'h0000, 3, 32'hDEAD_BEEF, 1'b0, 16'hABCD, 32'h0,        1, 0, 14'h4);
    vecs[3]  = mk(1'b1, SEG_A,        32'h1234_5678, 16'h0000, 2, 32'hDEAD_BEEF, 1'b0, 16'hABCD, 32'h12345678, 0, 0, 14'h0);
    vecs[4]  = mk(1'b0, SEG_A,        32'h0,         16'h0000, 2, 32'h1234_5678, 1'b0, 16'hABCD, 32'h12345678, 0, 0, 14'h0);
    vecs[5]  = mk(1'b0, LED_A,        32'h0,         16'h0000, 2, 32'h0000_ABCD, 1'b0, 16'hABCD, 32'h12345678, 0, 0, 14'h0);
    vecs[6]  = mk(1'b1, SW_A,         32'hFFFF_FFFF, 16'h0000, 2, 32'h0000_ABCD, 1'b0, 16'hABCD, 32'h12345678, 0, 0, 14'h0);
    vecs[7]  = mk(1'b0, SW_A,         32'h0,         16'h5A5A, 2, 32'h0000_5A5A, 1'b0, 16'hABCD, 32'h12345678, 0, 0, 14'h0);
    vecs[8]  = mk(1'b0, 32'h12,       32'h0,         16'h0000, 2, 32'h0000_0000, 1'b1, 16'hABCD, 32'h12345678, 0, 0, 14'h0);
    vecs[9]  = mk(1'b0, 32'h8000_0000, 32'h0,        16'h0000, 2, 32'h0000_0000, 1'b1, 16'hABCD, 32'h12345678, 0, 0, 14'h0);
    vecs[10] = mk(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 16'h0000, 2, 32'h0000_0000, 1'b1, 16'hABCD, 32'h12345678, 0, 0, 14'h0);
    vecs[11] = mk(1'b1, 32'h0000_FFFC, 32'hCAFE_F00D, 16'h0000, 2, 32'h0000_0000, 1'b0, 16'hABCD, 32'h12345678, 1, 1, 14'h3FFF);
    vecs[12] = mk(1'b0, 32'h0000_FFFC, 32'h0,        16'h0000, 3, 32'hCAFE_F00D, 1'b0, 16'hABCD, 32'h12345678, 1, 0, 14'h3FFF);
    vecs[13] = mk(1'b0, 32'h0001_0000, 32'h0,        16'h0000, 2, 32'h0000_0000, 1'b1, 16'hABCD, 32'h12345678, 0, 0, 14'h0);
    vecs[14] = mk(1'b0, 32'h10,       32'h0,         16'h0000, 3, 32'hDEAD_BEEF, 1'b0, 16'hABCD, 32'h12345678, 1, 0, 14'h4);
    vecs[15] = mk(1'b1, LED_A,        32'h1234_5678, 16'h0000, 2, 32'hDEAD_BEEF, 1'b0, 16'h5678, 32'h12345678, 0, 0, 14'h0);
    vecs[16] = mk(1'b1, 32'h13,       32'h0BAD_0BAD, 16'h0000, 2, 32'hDEAD_BEEF, 1'b1, 16'h5678, 32'h12345678, 0, 0, 14'h0);
    vecs[17] = mk(1'b0, 32'h10,       32'h0,         16'h0000, 3, 32'hDEAD_BEEF, 1'b0, 16'h5678, 32'h12345678, 1, 0, 14'h4);

    // Reset for two cycles, then idle with no request.
    repeat (2) @(negedge clk);
    check("reset led_out",   32'(led_out), 32'h0);
    check("reset seg_out",   seg_out,      32'h0);
    check("reset req_done",  32'(req_done), 32'h0);
    check("reset mem_en",    32'(mem_en),   32'h0);
    check("reset rsp_rdata", rsp_rdata,     32'h0);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("idle%0d req_done", c), 32'(req_done), 32'h0);
      check($sformatf("idle%0d mem_en", c),   32'(mem_en),   32'h0);
    end

    for (int i = 0; i < 18; i++) begin
      sw_in = vecs[i].sw;
      repeat (3) @(negedge clk);
      do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, rdata, err, en_n, we_n, maddr);
      check($sformatf("v%0d latency", i), 32'(lat),  32'(vecs[i].lat));
      check($sformatf("v%0d rdata", i),   rdata,     vecs[i].rdata);
      check($sformatf("v%0d err", i),     32'(err),  32'(vecs[i].err));
      check($sformatf("v%0d mem_en", i),  32'(en_n), 32'(vecs[i].en));
      check($sformatf("v%0d mem_we", i),  32'(we_n), 32'(vecs[i].we));
      if (vecs[i].en != 0) check($sformatf("v%0d mem_addr", i), 32'(maddr), 32'(vecs[i].maddr));
      @(negedge clk);
      check($sformatf("v%0d done pulse", i), 32'(req_done), 32'h0);
      check($sformatf("v%0d led_out", i),    32'(led_out),  32'(vecs[i].led));
      check($sformatf("v%0d seg_out", i),    seg_out,       vecs[i].seg);
    end

    // Reset lands during ACCESS of a memory store.
    req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h1111_1111; req_valid = 1'b1;
    @(negedge clk);
    check("abort mem_en before rst", 32'(mem_en), 32'h1);
    rst = 1'b1; req_valid = 1'b0;
    #1;
    check("abort mem_en gated", 32'(mem_en), 32'h0);
    check("abort mem_we gated", 32'(mem_we), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    check("abort mem word",  mem_model[8],  32'h0);
    check("abort led reset", 32'(led_out),  32'h0);
    check("abort seg reset", seg_out,       32'h0);
    check("abort rdata",     rsp_rdata,     32'h0);
    repeat (2) begin
      @(negedge clk);
      check("abort no done", 32'(req_done), 32'h0);
    end
    do_req(1'b0, 32'h20, 32'h0, lat, rdata, err, en_n, we_n, maddr);
    check("post-abort load latency", 32'(lat), 32'd3);
    check("post-abort load rdata",   rdata,    32'h0);
    @(negedge clk);
    do_req(1'b1, 32'h20, 32'h2222_2222, lat, rdata, err, en_n, we_n, maddr);
    check("post-abort store latency", 32'(lat),  32'd2);
    check("post-abort store we",      32'(we_n), 32'd1);
    @(negedge clk);
    do_req(1'b0, 32'h20, 32'h0, lat, rdata, err, en_n, we_n, maddr);
    check("post-abort readback", rdata,    32'h2222_2222);
    check("post-abort err",      32'(err), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
